// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST response analyzer: FSM state encoding
// and default datapath widths.
package mbist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 6;

endpackage

// File: rtl/mbist_cmp_stage.sv
// Stage-1 compare register: captures the XOR syndrome, its address and a
// mismatch flag for one compare; flush drops the pending entry.
module mbist_cmp_stage
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] syn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  mismatch
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] syn_q, syn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mismatch_q, mismatch_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    valid_d    = valid_q;
    syn_d      = syn_q;
    addr_d     = addr_q;
    mismatch_d = mismatch_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d    = 1'b1;
      syn_d      = rd_data ^ exp_data;
      addr_d     = rd_addr;
      mismatch_d = |(rd_data ^ exp_data);
    end else begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      syn_q      <= '0;
      addr_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      syn_q      <= syn_d;
      addr_q     <= addr_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign valid    = valid_q;
  assign syn      = syn_q;
  assign addr     = addr_q;
  assign mismatch = mismatch_q;

endmodule

// File: rtl/mbist_response_analyzer.sv
// MBIST read-back analyzer: session FSM, two-stage compare pipeline, fail
// status, saturating fail count and first-fail diagnostics.
// Optional fail-address log enabled by defining MBIST_FAIL_LOG_EN.
module mbist_response_analyzer
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 8,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         NbarT,
  input  logic                         start,
  input  logic                         cmp_valid,
  input  logic                         cmp_last,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  input  logic [DATA_WIDTH-1:0]        exp_data,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
`ifdef MBIST_FAIL_LOG_EN
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
  output logic [ADDR_WIDTH-1:0]        log_addr,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic [ADDR_WIDTH-1:0]        first_fail_addr,
  output logic [DATA_WIDTH-1:0]        first_fail_syn
);

  if (LOG_DEPTH < 2) begin : g_bad_log_depth
    $error("LOG_DEPTH must be at least 2");
  end

  state_e                state_q, state_d;
  logic                  fail_q, fail_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] first_fail_addr_q, first_fail_addr_d;
  logic [DATA_WIDTH-1:0] first_fail_syn_q, first_fail_syn_d;

  logic                  session_start;
  logic                  flush;
  logic                  capture;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_syn;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic                  s1_mismatch;
  logic                  hit;

  // start or leaving test mode both discard the in-flight compare.
  assign session_start = NbarT & start;
  assign flush         = ~NbarT | start;
  assign capture       = NbarT & ~start & (state_q == ST_RUN) & cmp_valid;
  assign hit           = s1_valid & s1_mismatch & NbarT & ~start;

  mbist_cmp_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cmp_stage (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .capture  (capture),
    .rd_data  (rd_data),
    .exp_data (exp_data),
    .rd_addr  (rd_addr),
    .valid    (s1_valid),
    .syn      (s1_syn),
    .addr     (s1_addr),
    .mismatch (s1_mismatch)
  );

  always_comb begin
    state_d = state_q;
    if (!NbarT) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (cmp_valid && cmp_last) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fail_d            = fail_q;
    fail_count_d      = fail_count_q;
    first_fail_addr_d = first_fail_addr_q;
    first_fail_syn_d  = first_fail_syn_q;
    if (session_start) begin
      fail_d            = 1'b0;
      fail_count_d      = '0;
      first_fail_addr_d = '0;
      first_fail_syn_d  = '0;
    end else if (hit) begin
      fail_d = 1'b1;
      if (!(&fail_count_q)) fail_count_d = fail_count_q + CNT_WIDTH'(1);
      if (!fail_q) begin
        first_fail_addr_d = s1_addr;
        first_fail_syn_d  = s1_syn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      fail_q            <= 1'b0;
      fail_count_q      <= '0;
      first_fail_addr_q <= '0;
      first_fail_syn_q  <= '0;
    end else begin
      state_q           <= state_d;
      fail_q            <= fail_d;
      fail_count_q      <= fail_count_d;
      first_fail_addr_q <= first_fail_addr_d;
      first_fail_syn_q  <= first_fail_syn_d;
    end
  end

  assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done            = (state_q == ST_DONE);
  assign fail            = fail_q;
  assign fail_count      = fail_count_q;
  assign first_fail_addr = first_fail_addr_q;
  assign first_fail_syn  = first_fail_syn_q;

`ifdef MBIST_FAIL_LOG_EN
  localparam int LOG_IDX_W = $clog2(LOG_DEPTH);
  localparam int LOG_CNT_W = LOG_IDX_W + 1;

  logic [LOG_CNT_W-1:0]  log_count_q, log_count_d;
  logic                  log_we;
  logic [ADDR_WIDTH-1:0] log_mem [LOG_DEPTH];

  assign log_we = hit && (log_count_q < LOG_CNT_W'(LOG_DEPTH));

  always_comb begin
    log_count_d = log_count_q;
    if (session_start)  log_count_d = '0;
    else if (log_we)    log_count_d = log_count_q + LOG_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) log_count_q <= '0;
    else     log_count_q <= log_count_d;
  end

  // NOTE: the log storage has no reset; log_count alone marks which
  // entries are valid, and stale entries are masked on read.
  always_ff @(posedge clk) begin
    if (log_we) log_mem[log_count_q[LOG_IDX_W-1:0]] <= s1_addr;
  end

  assign log_addr  = ({1'b0, log_idx} < log_count_q) ? log_mem[log_idx] : '0;
  assign log_count = log_count_q;
`endif

endmodule

// File: tb/tb_mbist_response_analyzer.sv
// Directed bench for mbist_response_analyzer; a second instance with a
// 2-bit fail counter covers saturation.
module tb_mbist_response_analyzer;

  logic       clk = 1'b0;
  logic       rst;
  logic       NbarT, start, cmp_valid, cmp_last;
  logic [7:0] rd_data, exp_data;
  logic [5:0] rd_addr;

  logic       busy, done, fail;
  logic [7:0] fail_count;
  logic [5:0] first_fail_addr;
  logic [7:0] first_fail_syn;

  logic       s_busy, s_done, s_fail;
  logic [1:0] s_fail_count;
  logic [5:0] s_first_fail_addr;
  logic [7:0] s_first_fail_syn;

`ifdef MBIST_FAIL_LOG_EN
  logic [1:0] log_idx;
  logic [5:0] log_addr, s_log_addr;
  logic [2:0] log_count, s_log_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mbist_response_analyzer u_dut (
    .clk(clk), .rst(rst), .NbarT(NbarT), .start(start),
    .cmp_valid(cmp_valid), .cmp_last(cmp_last),
    .rd_data(rd_data), .exp_data(exp_data), .rd_addr(rd_addr),
`ifdef MBIST_FAIL_LOG_EN
    .log_idx(log_idx), .log_addr(log_addr), .log_count(log_count),
`endif
    .busy(busy), .done(done), .fail(fail), .fail_count(fail_count),
    .first_fail_addr(first_fail_addr), .first_fail_syn(first_fail_syn)
  );

  mbist_response_analyzer #(.CNT_WIDTH(2)) u_dut_sat (
    .clk(clk), .rst(rst), .NbarT(NbarT), .start(start),
    .cmp_valid(cmp_valid), .cmp_last(cmp_last),
    .rd_data(rd_data), .exp_data(exp_data), .rd_addr(rd_addr),
`ifdef MBIST_FAIL_LOG_EN
    .log_idx(log_idx), .log_addr(s_log_addr), .log_count(s_log_count),
`endif
    .busy(s_busy), .done(s_done), .fail(s_fail), .fail_count(s_fail_count),
    .first_fail_addr(s_first_fail_addr), .first_fail_syn(s_first_fail_syn)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    NbarT = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_cmp(input logic [7:0] rd, input logic [7:0] ex,
                        input logic [5:0] a, input logic last);
    cmp_valid = 1'b1;
    cmp_last  = last;
    rd_data   = rd;
    exp_data  = ex;
    rd_addr   = a;
    step();
    cmp_valid = 1'b0;
    cmp_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; NbarT = 1'b0; start = 1'b0; cmp_valid = 1'b0; cmp_last = 1'b0;
    rd_data = '0; exp_data = '0; rd_addr = '0;
`ifdef MBIST_FAIL_LOG_EN
    log_idx = '0;
`endif
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_count", fail_count, 0);
    rst = 1'b0;
    step();

    // Clean pass
    do_start();
    check("pass_busy_run", busy, 1);
    for (int i = 0; i < 4; i++) do_cmp(8'hA5, 8'hA5, 6'(i), i == 3);
    check("pass_done_early", done, 0);
    check("pass_busy_drain", busy, 1);
    step();
    check("pass_done", done, 1);
    check("pass_busy_done", busy, 0);
    check("pass_fail", fail, 0);
    check("pass_count", fail_count, 0);

    // Single fail
    do_start();
    check("sf_done_clr", done, 0);
    do_cmp(8'hA5, 8'hA5, 6'h04, 1'b0);
    do_cmp(8'hA5, 8'h3C, 6'h05, 1'b0);
    check("sf_latency", fail, 0);
    do_cmp(8'hA5, 8'hA5, 6'h06, 1'b1);
    check("sf_fail", fail, 1);
    step();
    check("sf_done", done, 1);
    check("sf_count", fail_count, 1);
    check("sf_addr", first_fail_addr, 6'h05);
    check("sf_syn", first_fail_syn, 8'h99);

    // Multiple fails
    do_start();
    check("mf_clr_fail", fail, 0);
    check("mf_clr_count", fail_count, 0);
    do_cmp(8'h0F, 8'h00, 6'h07, 1'b0);
    do_cmp(8'h33, 8'h33, 6'h08, 1'b0);
    do_cmp(8'hFF, 8'h00, 6'h0A, 1'b1);
    step();
    check("mf_count", fail_count, 2);
    check("mf_addr", first_fail_addr, 6'h07);
    check("mf_syn", first_fail_syn, 8'h0F);
    check("mf_sat_count", s_fail_count, 2);
`ifdef MBIST_FAIL_LOG_EN
    check("mf_log_count", log_count, 2);
    log_idx = 2'd0; #1 check("mf_log0", log_addr, 6'h07);
    log_idx = 2'd1; #1 check("mf_log1", log_addr, 6'h0A);
    log_idx = 2'd2; #1 check("mf_log2_empty", log_addr, 6'h00);
`endif

    // Saturation: five consecutive mismatches
    do_start();
    for (int i = 0; i < 5; i++) do_cmp(8'h00, 8'h01, 6'(16 + i), i == 4);
    step();
    check("sat_done", s_done, 1);
    check("sat_count", s_fail_count, 3);
    check("sat_wide_count", fail_count, 5);
    check("sat_addr", first_fail_addr, 6'h10);
    check("sat_syn", first_fail_syn, 8'h01);
    step();
    check("sat_hold", s_fail_count, 3);
`ifdef MBIST_FAIL_LOG_EN
    check("sat_log_count", log_count, 4);
    log_idx = 2'd3; #1 check("sat_log3", log_addr, 6'h13);
`endif

    // Abort mid-session with one counted fail and one in flight
    do_start();
    do_cmp(8'h01, 8'h00, 6'h01, 1'b0);
    do_cmp(8'h02, 8'h00, 6'h02, 1'b0);
    check("ab_fail_pre", fail, 1);
    NbarT = 1'b0;
    step();
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_fail_held", fail, 1);
    check("ab_count_held", fail_count, 1);
    check("ab_addr_held", first_fail_addr, 6'h01);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ab_start_ignored", busy, 0);
    check("ab_fail_still", fail, 1);

    // Restart with a compare coincident with start (ignored),
    // then a one-compare session on the first RUN cycle
    NbarT = 1'b1; start = 1'b1; cmp_valid = 1'b1;
    rd_data = 8'hF0; exp_data = 8'h00; rd_addr = 6'h2A;
    step();
    start = 1'b0; cmp_valid = 1'b0;
    check("rs_busy", busy, 1);
    check("rs_fail_clr", fail, 0);
    check("rs_count_clr", fail_count, 0);
    do_cmp(8'h00, 8'h80, 6'h3F, 1'b1);
    step();
    check("one_done", done, 1);
    check("one_count", fail_count, 1);
    check("one_addr", first_fail_addr, 6'h3F);
    check("one_syn", first_fail_syn, 8'h80);

    // start in RUN drops the pending stage-1 mismatch
    do_start();
    do_cmp(8'h55, 8'hAA, 6'h09, 1'b0);
    do_start();
    step();
    check("rr_fail", fail, 0);
    check("rr_count", fail_count, 0);
    check("rr_busy", busy, 1);

    // Async reset with a pending mismatch in stage 1
    do_cmp(8'h11, 8'h00, 6'h04, 1'b0);
    do_cmp(8'h22, 8'h00, 6'h05, 1'b0);
    check("ar_fail_pre", fail, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_fail", fail, 0);
    check("ar_count", fail_count, 0);
    check("ar_busy", busy, 0);
    check("ar_addr", first_fail_addr, 0);
    check("ar_syn", first_fail_syn, 0);
`ifdef MBIST_FAIL_LOG_EN
    check("ar_log_count", log_count, 0);
`endif
    step();
    rst = 1'b0;
    step(); step();
    check("ar_post_fail", fail, 0);
    check("ar_post_count", fail_count, 0);
    check("ar_post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
